// File: rtl/player_timers_if.sv
// Bundle of the time-base, enable and result signals exchanged between the
// Switch side (master) and the player_timers countdown block (slave).
interface player_timers_if;
  logic        CE;
  logic        Enable_p1;
  logic        Enable_p2;
  logic [15:0] P1_TIME;
  logic [15:0] P2_TIME;
  logic        END;
  logic        FLAG_P1;
  logic        FLAG_P2;

  modport master (
    output CE, Enable_p1, Enable_p2,
    input  P1_TIME, P2_TIME, END, FLAG_P1, FLAG_P2
  );

  modport slave (
    input  CE, Enable_p1, Enable_p2,
    output P1_TIME, P2_TIME, END, FLAG_P1, FLAG_P2
  );
endinterface

// File: rtl/player_timers.sv
// Two-player chess clock: BCD mm:ss countdown per player, optional Fischer
// increment on move completion, and flag/END latching when a clock hits 00:00.
module player_timers #(
  parameter int INIT_MIN = 5,
  parameter int INIT_SEC = 0,
  parameter int INC_SEC  = 0
) (
  input  logic            CLK,
  input  logic            CLR,
  player_timers_if.slave  bus
);

  typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

  localparam logic [15:0] INIT_BCD = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10),
                                      4'(INIT_SEC / 10), 4'(INIT_SEC % 10)};

  // Subtract one second from a nonzero BCD mm:ss value.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  // Add the increment to a BCD mm:ss value, carrying seconds into minutes
  // and saturating at 99:59.
  function automatic logic [15:0] bcd_add(input logic [15:0] t);
    logic [6:0] secs;
    logic [6:0] mins;
    secs = 7'(t[7:4]) * 7'd10 + 7'(t[3:0]) + 7'(INC_SEC);
    mins = 7'(t[15:12]) * 7'd10 + 7'(t[11:8]);
    if (secs >= 7'd60) begin
      secs = secs - 7'd60;
      mins = mins + 7'd1;
    end
    if (mins > 7'd99) begin
      return 16'h9959;
    end
    return {4'(mins / 7'd10), 4'(mins % 7'd10), 4'(secs / 7'd10), 4'(secs % 7'd10)};
  endfunction

  state_t            state_reg, state_next;
  logic [1:0][15:0]  time_reg;
  logic [1:0][15:0]  time_next;
  logic [1:0]        prev_en_reg;
  logic [1:0]        flag_reg, flag_next;
  logic              end_reg, end_next;
  logic [1:0]        en;
  logic [1:0]        zero;

  assign en = {bus.Enable_p2, bus.Enable_p1};

  // Per-player datapath: index 0 is player 1, index 1 is player 2.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_player
      logic dec_hit;
      logic inc_hit;
      assign zero[gi]  = (time_reg[gi] == 16'h0000);
      // Only the player whose clock runs alone counts down; both-high is illegal and freezes both.
      assign dec_hit   = (state_reg == RUN) && bus.CE && en[gi] && !en[1 - gi] && !zero[gi];
      // Falling enable marks a completed move; a flagged player never gets time back.
      assign inc_hit   = (INC_SEC > 0) && (state_reg == RUN) && prev_en_reg[gi] && !en[gi]
                         && !zero[gi];
      assign time_next[gi] = dec_hit ? bcd_dec(time_reg[gi]) :
                             inc_hit ? bcd_add(time_reg[gi]) : time_reg[gi];
    end
  endgenerate

  // State register.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: leave RUN as soon as either registered time reads 00:00.
  always_comb begin
    state_next = state_reg;
    if (state_reg == RUN && zero != 2'b00) begin
      state_next = DONE;
    end
  end

  // Outputs: raise END and latch every flagged player on the RUN -> DONE edge.
  always_comb begin
    end_next  = end_reg;
    flag_next = flag_reg;
    if (state_reg == RUN && zero != 2'b00) begin
      end_next  = 1'b1;
      flag_next = flag_reg | zero;
    end
  end

  // Datapath registers; enable history is tracked in every state.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      time_reg    <= {INIT_BCD, INIT_BCD};
      prev_en_reg <= 2'b00;
      flag_reg    <= 2'b00;
      end_reg     <= 1'b0;
    end else begin
      time_reg    <= time_next;
      prev_en_reg <= en;
      flag_reg    <= flag_next;
      end_reg     <= end_next;
    end
  end

  assign bus.P1_TIME = time_reg[0];
  assign bus.P2_TIME = time_reg[1];
  assign bus.END     = end_reg;
  assign bus.FLAG_P1 = flag_reg[0];
  assign bus.FLAG_P2 = flag_reg[1];

endmodule

// File: tb/tb_player_timers.sv
// Directed bench for player_timers using three parameterisations:
// a = 00:03 no increment, b = 01:00 +5 s, c = 99:59 +5 s.
module tb_player_timers;
  logic CLK = 1'b0;
  logic CLR = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  player_timers_if ifa ();
  player_timers_if ifb ();
  player_timers_if ifc ();

  player_timers #(.INIT_MIN(0),  .INIT_SEC(3),  .INC_SEC(0)) dut_a (.CLK(CLK), .CLR(CLR), .bus(ifa.slave));
  player_timers #(.INIT_MIN(1),  .INIT_SEC(0),  .INC_SEC(5)) dut_b (.CLK(CLK), .CLR(CLR), .bus(ifb.slave));
  player_timers #(.INIT_MIN(99), .INIT_SEC(59), .INC_SEC(5)) dut_c (.CLK(CLK), .CLR(CLR), .bus(ifc.slave));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.CE = 0; ifa.Enable_p1 = 0; ifa.Enable_p2 = 0;
    ifb.CE = 0; ifb.Enable_p1 = 0; ifb.Enable_p2 = 0;
    ifc.CE = 0; ifc.Enable_p1 = 0; ifc.Enable_p2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    CLR = 1;
    tick();
    CLR = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (ifa.P1_TIME !== 16'h0003) begin fails++; $display("FAIL reset_a_p1: got %h want 0003", ifa.P1_TIME); end
    tests++; if (ifa.P2_TIME !== 16'h0003) begin fails++; $display("FAIL reset_a_p2: got %h want 0003", ifa.P2_TIME); end
    tests++; if ({ifa.END, ifa.FLAG_P1, ifa.FLAG_P2} !== 3'b000) begin fails++; $display("FAIL reset_a_flags: got %b want 000", {ifa.END, ifa.FLAG_P1, ifa.FLAG_P2}); end
    tests++; if (ifb.P1_TIME !== 16'h0100) begin fails++; $display("FAIL reset_b_p1: got %h want 0100", ifb.P1_TIME); end
    tests++; if (ifc.P2_TIME !== 16'h9959) begin fails++; $display("FAIL reset_c_p2: got %h want 9959", ifc.P2_TIME); end
    $display("[TB] test_reset done");
  endtask

  // 00:03 counts down to flag fall; END follows the zero by one edge.
  task automatic test_countdown();
    logic [15:0] exp_t [3];
    exp_t[0] = 16'h0002; exp_t[1] = 16'h0001; exp_t[2] = 16'h0000;
    do_reset();
    ifa.Enable_p1 = 1;
    for (int i = 0; i < 3; i++) begin
      ifa.CE = 1; tick(); ifa.CE = 0; tick();
      tests++; if (ifa.P1_TIME !== exp_t[i]) begin fails++; $display("FAIL countdown_p1_%0d: got %h want %h", i, ifa.P1_TIME, exp_t[i]); end
    end
    // After the idle edge following the last pulse, END is already up.
    tests++; if ({ifa.END, ifa.FLAG_P1, ifa.FLAG_P2} !== 3'b110) begin fails++; $display("FAIL countdown_flags: got %b want 110", {ifa.END, ifa.FLAG_P1, ifa.FLAG_P2}); end
    tests++; if (ifa.P2_TIME !== 16'h0003) begin fails++; $display("FAIL countdown_p2: got %h want 0003", ifa.P2_TIME); end
    $display("[TB] test_countdown done");
  endtask

  // END latency: exactly one edge after the zero-reaching decrement.
  task automatic test_end_latency();
    do_reset();
    ifa.Enable_p1 = 1;
    for (int i = 0; i < 2; i++) begin ifa.CE = 1; tick(); ifa.CE = 0; end
    ifa.CE = 1; tick(); ifa.CE = 0;
    tests++; if ({ifa.P1_TIME, ifa.END} !== {16'h0000, 1'b0}) begin fails++; $display("FAIL latency_pre: got %h/%b want 0000/0", ifa.P1_TIME, ifa.END); end
    tick();
    tests++; if (ifa.END !== 1'b1) begin fails++; $display("FAIL latency_post: got %b want 1", ifa.END); end
    $display("[TB] test_end_latency done");
  endtask

  // After END, everything is frozen until CLR.
  task automatic test_done_frozen();
    ifa.Enable_p1 = 0; ifa.Enable_p2 = 1;
    for (int i = 0; i < 3; i++) begin ifa.CE = 1; tick(); ifa.CE = 0; tick(); end
    ifa.Enable_p2 = 0; ifa.Enable_p1 = 1; tick(); ifa.Enable_p1 = 0; tick();
    tests++; if (ifa.P1_TIME !== 16'h0000) begin fails++; $display("FAIL frozen_p1: got %h want 0000", ifa.P1_TIME); end
    tests++; if (ifa.P2_TIME !== 16'h0003) begin fails++; $display("FAIL frozen_p2: got %h want 0003", ifa.P2_TIME); end
    tests++; if ({ifa.END, ifa.FLAG_P1, ifa.FLAG_P2} !== 3'b110) begin fails++; $display("FAIL frozen_flags: got %b want 110", {ifa.END, ifa.FLAG_P1, ifa.FLAG_P2}); end
    do_reset();
    tests++; if ({ifa.P1_TIME, ifa.P2_TIME} !== 32'h0003_0003) begin fails++; $display("FAIL clr_times: got %h want 00030003", {ifa.P1_TIME, ifa.P2_TIME}); end
    tests++; if ({ifa.END, ifa.FLAG_P1, ifa.FLAG_P2} !== 3'b000) begin fails++; $display("FAIL clr_flags: got %b want 000", {ifa.END, ifa.FLAG_P1, ifa.FLAG_P2}); end
    $display("[TB] test_done_frozen done");
  endtask

  // Both enables high is illegal: nothing moves; CE alone also does nothing.
  task automatic test_both_enables();
    do_reset();
    ifa.Enable_p1 = 1; ifa.Enable_p2 = 1;
    for (int i = 0; i < 4; i++) begin ifa.CE = 1; tick(); ifa.CE = 0; tick(); end
    ifa.Enable_p1 = 0; ifa.Enable_p2 = 0;
    ifa.CE = 1; tick(); ifa.CE = 0; tick();
    tests++; if ({ifa.P1_TIME, ifa.P2_TIME} !== 32'h0003_0003) begin fails++; $display("FAIL both_en_times: got %h want 00030003", {ifa.P1_TIME, ifa.P2_TIME}); end
    tests++; if (ifa.END !== 1'b0) begin fails++; $display("FAIL both_en_end: got %b want 0", ifa.END); end
    $display("[TB] test_both_enables done");
  endtask

  // Minute borrow on P2, then the increment on its move completion.
  task automatic test_borrow_and_inc();
    do_reset();
    ifb.Enable_p2 = 1;
    ifb.CE = 1; tick(); ifb.CE = 0;
    tests++; if (ifb.P2_TIME !== 16'h0059) begin fails++; $display("FAIL borrow_p2: got %h want 0059", ifb.P2_TIME); end
    tests++; if (ifb.P1_TIME !== 16'h0100) begin fails++; $display("FAIL borrow_p1: got %h want 0100", ifb.P1_TIME); end
    ifb.Enable_p2 = 0; tick();
    tests++; if (ifb.P2_TIME !== 16'h0104) begin fails++; $display("FAIL inc_p2: got %h want 0104", ifb.P2_TIME); end
    $display("[TB] test_borrow_and_inc done");
  endtask

  // Increment carry (00:58 + 5 = 01:03) and saturation (99:57 + 5 = 99:59).
  task automatic test_inc_carry_sat();
    do_reset();
    ifb.Enable_p1 = 1; ifc.Enable_p1 = 1;
    for (int i = 0; i < 2; i++) begin ifb.CE = 1; ifc.CE = 1; tick(); ifb.CE = 0; ifc.CE = 0; end
    tests++; if (ifb.P1_TIME !== 16'h0058) begin fails++; $display("FAIL pre_carry: got %h want 0058", ifb.P1_TIME); end
    tests++; if (ifc.P1_TIME !== 16'h9957) begin fails++; $display("FAIL pre_sat: got %h want 9957", ifc.P1_TIME); end
    ifb.Enable_p1 = 0; ifc.Enable_p1 = 0; tick();
    tests++; if (ifb.P1_TIME !== 16'h0103) begin fails++; $display("FAIL inc_carry: got %h want 0103", ifb.P1_TIME); end
    tests++; if (ifc.P1_TIME !== 16'h9959) begin fails++; $display("FAIL inc_sat: got %h want 9959", ifc.P1_TIME); end
    $display("[TB] test_inc_carry_sat done");
  endtask

  // Hand-over: P2 releases while P1 starts on a CE edge; both updates land.
  task automatic test_back_to_back();
    do_reset();
    ifb.Enable_p2 = 1; tick();
    ifb.Enable_p2 = 0; ifb.Enable_p1 = 1; ifb.CE = 1; tick(); ifb.CE = 0;
    tests++; if (ifb.P1_TIME !== 16'h0059) begin fails++; $display("FAIL b2b_p1: got %h want 0059", ifb.P1_TIME); end
    tests++; if (ifb.P2_TIME !== 16'h0105) begin fails++; $display("FAIL b2b_p2: got %h want 0105", ifb.P2_TIME); end
    $display("[TB] test_back_to_back done");
  endtask

  // CLR on the same edge as a CE pulse: reset wins, and no stale increment follows.
  task automatic test_clr_with_ce();
    ifb.Enable_p1 = 1; ifb.CE = 1; CLR = 1; tick();
    CLR = 0; ifb.CE = 0;
    tests++; if (ifb.P1_TIME !== 16'h0100) begin fails++; $display("FAIL clr_ce_p1: got %h want 0100", ifb.P1_TIME); end
    ifb.Enable_p1 = 0; tick();
    tests++; if (ifb.P1_TIME !== 16'h0100) begin fails++; $display("FAIL clr_ce_noinc: got %h want 0100", ifb.P1_TIME); end
    $display("[TB] test_clr_with_ce done");
  endtask

  initial begin
    idle_inputs();
    tick();
    test_reset();
    test_countdown();
    test_done_frozen();
    test_end_latency();
    test_both_enables();
    test_borrow_and_inc();
    test_inc_carry_sat();
    test_back_to_back();
    test_clr_with_ce();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
